// File: rtl/axi_two_stage_pipe.sv
// Two cascaded valid/ready register slices; breaks timing between producer and consumer.
// Define AXI_PIPE_SKID_EN to build each stage as a 2-entry skid buffer with registered ready.

module axi_pipe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_val,
    input  logic                  out_rdy
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  val_q,  val_d;

`ifdef AXI_PIPE_SKID_EN
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  skid_val_q, skid_val_d;

    // Ready comes straight from a flop, so out_rdy never reaches in_rdy combinationally.
    assign in_rdy = !skid_val_q;

    always_comb begin
        data_d     = data_q;
        val_d      = val_q;
        skid_d     = skid_q;
        skid_val_d = skid_val_q;
        if (skid_val_q) begin
            if (out_rdy) begin
                data_d     = skid_q;
                skid_val_d = 1'b0;
            end
        end else if (in_val) begin
            if (!val_q || out_rdy) begin
                data_d = in_data;
                val_d  = 1'b1;
            end else begin
                skid_d     = in_data;
                skid_val_d = 1'b1;
            end
        end else if (out_rdy) begin
            val_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            val_q      <= 1'b0;
            skid_q     <= '0;
            skid_val_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            val_q      <= val_d;
            skid_q     <= skid_d;
            skid_val_q <= skid_val_d;
        end
    end
`else
    assign in_rdy = !val_q || out_rdy;

    always_comb begin
        data_d = data_q;
        val_d  = val_q;
        if (in_val && in_rdy) begin
            data_d = in_data;
            val_d  = 1'b1;
        end else if (out_rdy) begin
            val_d = 1'b0;
        end
    end

    // NOTE: data registers are reset too, so the output bus reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            val_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            val_q  <= val_d;
        end
    end
`endif

    assign out_data = data_q;
    assign out_val  = val_q;

endmodule

module axi_two_stage_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] up_bus,
    input  logic                  up_val,
    output logic                  up_rdy,
    input  logic                  dn_rdy_next_stage,
    output logic                  dn_val_slave,
    output logic [DATA_WIDTH-1:0] dn_bus_slave
);

    logic [DATA_WIDTH-1:0] dn_bus;
    logic                  dn_val;
    logic                  dn_rdy;

    axi_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage_a (
        .clk      (clk),
        .rst      (rst),
        .in_data  (up_bus),
        .in_val   (up_val),
        .in_rdy   (up_rdy),
        .out_data (dn_bus),
        .out_val  (dn_val),
        .out_rdy  (dn_rdy)
    );

    axi_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  (dn_bus),
        .in_val   (dn_val),
        .in_rdy   (dn_rdy),
        .out_data (dn_bus_slave),
        .out_val  (dn_val_slave),
        .out_rdy  (dn_rdy_next_stage)
    );

endmodule

// File: tb/tb_axi_two_stage_pipe.sv
// Self-checking bench for axi_two_stage_pipe: ordered-queue model plus directed literal checks.
// Runs a 32-bit instance and a 7-bit instance side by side on the same handshakes.

module tb_axi_two_stage_pipe;

`ifdef AXI_PIPE_SKID_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] up_bus;
    logic        up_val;
    logic        up_rdy;
    logic        dn_rdy_next_stage;
    logic        dn_val_slave;
    logic [31:0] dn_bus_slave;
    logic        w7_rdy;
    logic        w7_val;
    logic [6:0]  w7_bus;

    always #5 clk = ~clk;

    axi_two_stage_pipe #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .up_bus            (up_bus),
        .up_val            (up_val),
        .up_rdy            (up_rdy),
        .dn_rdy_next_stage (dn_rdy_next_stage),
        .dn_val_slave      (dn_val_slave),
        .dn_bus_slave      (dn_bus_slave)
    );

    axi_two_stage_pipe #(.DATA_WIDTH(7)) dut7 (
        .clk               (clk),
        .rst               (rst),
        .up_bus            (up_bus[6:0]),
        .up_val            (up_val),
        .up_rdy            (w7_rdy),
        .dn_rdy_next_stage (dn_rdy_next_stage),
        .dn_val_slave      (w7_val),
        .dn_bus_slave      (w7_bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Model: words in flight in arrival order, each tagged with the edge count at which
    // it may first appear at the output (one edge after acceptance).
    logic [31:0] mq[$];
    int          mtag[$];
    int          edge_n = 0;
    logic        mval;
    logic [31:0] head;
    logic [31:0] seen[$];
    logic [6:0]  seen7[$];

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_val", {31'b0, dn_val_slave}, 32'd0);
            check("rst_bus", dn_bus_slave, 32'd0);
            check("rst_rdy", {31'b0, up_rdy}, 32'd1);
            check("rst_val7", {31'b0, w7_val}, 32'd0);
            mq.delete();
            mtag.delete();
        end else begin
            mval = (mq.size() > 0) && (mtag[0] < edge_n);
            head = (mq.size() > 0) ? mq[0] : 32'd0;
            check("out_val", {31'b0, dn_val_slave}, {31'b0, mval});
            check("out_val7", {31'b0, w7_val}, {31'b0, mval});
            if (mval) begin
                check("out_bus", dn_bus_slave, head);
                check("out_bus7", {25'b0, w7_bus}, {25'b0, head[6:0]});
            end
`ifdef AXI_PIPE_SKID_EN
            if (mq.size() <= 2) begin
                check("up_rdy", {31'b0, up_rdy}, 32'd1);
                check("up_rdy7", {31'b0, w7_rdy}, 32'd1);
            end else if (mq.size() == 4) begin
                check("up_rdy", {31'b0, up_rdy}, 32'd0);
                check("up_rdy7", {31'b0, w7_rdy}, 32'd0);
            end
`else
            check("up_rdy", {31'b0, up_rdy}, {31'b0, (mq.size() < 2) || dn_rdy_next_stage});
            check("up_rdy7", {31'b0, w7_rdy}, {31'b0, (mq.size() < 2) || dn_rdy_next_stage});
`endif
            if (dn_val_slave && dn_rdy_next_stage) begin
                seen.push_back(dn_bus_slave);
                seen7.push_back(w7_bus);
            end
            if (mval && dn_rdy_next_stage) begin
                void'(mq.pop_front());
                void'(mtag.pop_front());
            end
            if (up_val && up_rdy) begin
                mq.push_back(up_bus);
                mtag.push_back(edge_n + 1);
            end
        end
        edge_n++;
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        up_val            = v;
        up_bus            = d;
        dn_rdy_next_stage = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b1);
    endtask

    // Offers base+nacc each cycle until limit words are taken; holds a word until accepted.
    int          nacc;
    logic [31:0] base;
    task automatic run(input int cycles, input logic r, input int limit);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            up_val            = (nacc < limit);
            up_bus            = base + nacc;
            dn_rdy_next_stage = r;
            #1;
            acc = up_val && up_rdy;
            @(posedge clk);
            #1;
            if (acc) nacc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int thru_start;
        rst = 1'b0;
        up_val = 1'b0;
        up_bus = 32'd0;
        dn_rdy_next_stage = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Streaming: each word visible one edge after its acceptance edge.
        seen.delete();
        drive(1'b1, 32'h59, 1'b1);
        drive(1'b1, 32'h71, 1'b1);
        check("stream_bus0", dn_bus_slave, 32'h59);
        check("stream_val0", {31'b0, dn_val_slave}, 32'd1);
        drive(1'b1, 32'h5B, 1'b1);
        check("stream_bus1", dn_bus_slave, 32'h71);
        drive(1'b0, 32'h0, 1'b1);
        check("stream_bus2", dn_bus_slave, 32'h5B);
        idle(3);
        check("stream_count", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            check("stream_seq0", seen[0], 32'h59);
            check("stream_seq1", seen[1], 32'h71);
            check("stream_seq2", seen[2], 32'h5B);
        end

        // Bubble passes through as one idle output cycle.
        drive(1'b1, 32'h59, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("bubble_bus0", dn_bus_slave, 32'h59);
        drive(1'b1, 32'h79, 1'b1);
        check("bubble_idle", {31'b0, dn_val_slave}, 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        check("bubble_val1", {31'b0, dn_val_slave}, 32'd1);
        check("bubble_bus1", dn_bus_slave, 32'h79);
        idle(3);

        // Backpressure: stall fills the pipe to capacity, then release drains in order.
        seen.delete();
        nacc = 0;
        base = 32'd1;
        run(10, 1'b0, 5);
        check("bp_accepted", nacc, CAP);
        check("bp_up_rdy", {31'b0, up_rdy}, 32'd0);
        check("bp_hold_bus", dn_bus_slave, 32'h01);
        check("bp_hold_val", {31'b0, dn_val_slave}, 32'd1);
        run(20, 1'b1, 5);
        idle(4);
        check("bp_count", seen.size(), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++) check("bp_seq", seen[i], 32'(i + 1));

        // Simultaneous drain and accept from a full pipe.
        seen.delete();
        nacc = 0;
        base = 32'h100;
        run(6, 1'b0, CAP);
        run(2, 1'b1, 1000);
        thru_start = nacc;
        for (int c = 0; c < 10; c++) begin
            up_val = 1'b1;
            up_bus = base + nacc;
            dn_rdy_next_stage = 1'b1;
            #1;
            check("thru_rdy", {31'b0, up_rdy}, 32'd1);
            @(posedge clk);
            #1;
            nacc++;
        end
        check("thru_count", nacc - thru_start, 32'd10);
        idle(6);
        check("thru_seen", seen.size(), nacc);
        for (int i = 0; i < seen.size(); i++) check("thru_seq", seen[i], 32'h100 + 32'(i));

        // Width: the 7-bit instance sees only the low bits of the same words.
        seen.delete();
        seen7.delete();
        drive(1'b1, 32'hA5A5A5FF, 1'b1);
        drive(1'b1, 32'h5A5A5A80, 1'b1);
        idle(4);
        check("w7_count", seen7.size(), 32'd2);
        if (seen7.size() == 2 && seen.size() == 2) begin
            check("w7_word0", {25'b0, seen7[0]}, 32'h7F);
            check("w7_word1", {25'b0, seen7[1]}, 32'h00);
            check("w32_word0", seen[0], 32'hA5A5A5FF);
            check("w32_word1", seen[1], 32'h5A5A5A80);
        end

        // Mid-stream reset drops in-flight words immediately.
        drive(1'b1, 32'h11, 1'b1);
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b0);
        up_val = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mr_val", {31'b0, dn_val_slave}, 32'd0);
        check("mr_bus", dn_bus_slave, 32'd0);
        check("mr_rdy", {31'b0, up_rdy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen.delete();
        idle(5);
        check("mr_nothing_out", seen.size(), 32'd0);
        check("mr_val_after", {31'b0, dn_val_slave}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
